// File: rtl/subneg_ctrl.sv
// -----------------------------------------------------------------------------
// subneg_ctrl
// Control sequencer for the SUBNEG one-instruction datapath. Each instruction
// is the three-word triple A, B, C and performs
//     mem[B] = mem[B] - mem[A]; if (result < 0) PC = C
// as a fixed 10-state sequence against a memory with 1-cycle read latency.
//
// Optional feature macro: SUBNEG_STEP_EN
//   When defined, a `step` input and a PAUSE state are added. After WRITE the
//   sequencer waits in PAUSE until `step` is sampled high.
//
// Ports
//   clk        in   clock, rising-edge
//   rst        in   synchronous active-high reset
//   start      in   begin execution (sampled only in IDLE)
//   pc         in   [WIDTH] current PC from the datapath
//   neg        in   sign of (opb - opa), valid in WRITE
//   step       in   single-step advance (SUBNEG_STEP_EN only)
//   addr_sel   out  [2] address mux: 0 = PC, 1 = A reg, 2 = B reg
//   pc_sel     out  PC mux: 0 = PC+1, 1 = C reg
//   pc_en      out  PC load enable
//   a_en/b_en/c_en   out  instruction-word register enables
//   opa_en/opb_en    out  operand register enables
//   mem_we     out  memory write strobe
//   busy       out  high outside IDLE and HALT
//   halted     out  high in HALT
//   instr_done out  one-cycle pulse in WRITE
// -----------------------------------------------------------------------------
module subneg_ctrl #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] HALT_ADDR = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] pc,
    input  logic             neg,
`ifdef SUBNEG_STEP_EN
    input  logic             step,
`endif
    output logic [1:0]       addr_sel,
    output logic             pc_sel,
    output logic             pc_en,
    output logic             a_en,
    output logic             b_en,
    output logic             c_en,
    output logic             opa_en,
    output logic             opb_en,
    output logic             mem_we,
    output logic             busy,
    output logic             halted,
    output logic             instr_done
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_FETCH_A = 4'd1,
        S_LOAD_A  = 4'd2,
        S_FETCH_B = 4'd3,
        S_LOAD_B  = 4'd4,
        S_FETCH_C = 4'd5,
        S_LOAD_C  = 4'd6,
        S_READ_A  = 4'd7,
        S_CAP_A   = 4'd8,
        S_CAP_B   = 4'd9,
        S_WRITE   = 4'd10,
`ifdef SUBNEG_STEP_EN
        S_PAUSE   = 4'd12,
`endif
        S_HALT    = 4'd11
    } state_t;

    state_t r_state;
    state_t w_next;
    logic   w_halt_hit;

    assign w_halt_hit = (pc == HALT_ADDR);

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_FETCH_A;
                end else begin
                    w_next = S_IDLE;
                end
            end
            // The halt check lives only here, so a branch to HALT_ADDR
            // completes its write before stopping.
            S_FETCH_A: begin
                if (w_halt_hit) begin
                    w_next = S_HALT;
                end else begin
                    w_next = S_LOAD_A;
                end
            end
            S_LOAD_A:  w_next = S_FETCH_B;
            S_FETCH_B: w_next = S_LOAD_B;
            S_LOAD_B:  w_next = S_FETCH_C;
            S_FETCH_C: w_next = S_LOAD_C;
            S_LOAD_C:  w_next = S_READ_A;
            S_READ_A:  w_next = S_CAP_A;
            S_CAP_A:   w_next = S_CAP_B;
            S_CAP_B:   w_next = S_WRITE;
`ifdef SUBNEG_STEP_EN
            S_WRITE:   w_next = S_PAUSE;
            S_PAUSE: begin
                if (step) begin
                    w_next = S_FETCH_A;
                end else begin
                    w_next = S_PAUSE;
                end
            end
`else
            S_WRITE:   w_next = S_FETCH_A;
`endif
            S_HALT:    w_next = S_HALT;
            default:   w_next = S_IDLE;
        endcase
    end

    // Moore output decode; only pc_en/pc_sel in WRITE look at neg.
    // Each register enable trails its address state by one cycle to match
    // the memory read latency.
    always_comb begin
        addr_sel   = 2'd0;
        pc_sel     = 1'b0;
        pc_en      = 1'b0;
        a_en       = 1'b0;
        b_en       = 1'b0;
        c_en       = 1'b0;
        opa_en     = 1'b0;
        opb_en     = 1'b0;
        mem_we     = 1'b0;
        busy       = 1'b1;
        halted     = 1'b0;
        instr_done = 1'b0;
        case (r_state)
            S_IDLE:    busy = 1'b0;
            S_FETCH_A: addr_sel = 2'd0;
            S_LOAD_A: begin
                a_en  = 1'b1;
                pc_en = 1'b1;
            end
            S_FETCH_B: addr_sel = 2'd0;
            S_LOAD_B: begin
                b_en  = 1'b1;
                pc_en = 1'b1;
            end
            S_FETCH_C: addr_sel = 2'd0;
            S_LOAD_C: begin
                c_en  = 1'b1;
                pc_en = 1'b1;
            end
            S_READ_A:  addr_sel = 2'd1;
            S_CAP_A: begin
                opa_en   = 1'b1;
                addr_sel = 2'd2;
            end
            S_CAP_B: begin
                opb_en   = 1'b1;
                addr_sel = 2'd2;
            end
            S_WRITE: begin
                addr_sel   = 2'd2;
                mem_we     = 1'b1;
                instr_done = 1'b1;
                // Strictly negative branches; a zero result falls through.
                if (neg) begin
                    pc_en  = 1'b1;
                    pc_sel = 1'b1;
                end else begin
                    pc_en  = 1'b0;
                    pc_sel = 1'b0;
                end
            end
`ifdef SUBNEG_STEP_EN
            S_PAUSE:   busy = 1'b1;
`endif
            S_HALT: begin
                busy   = 1'b0;
                halted = 1'b1;
            end
            default:   busy = 1'b0;
        endcase
    end

endmodule
